// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and per-grant time slicing.
// Latency: grant rises 1 cycle after req is sampled in IDLE; two grant-low cycles between grants.
// Backpressure: en low blocks new grants only; a grant ends on req drop or slice expiry.
module rr_ring_arbiter #(
    parameter int N     = 4,
    parameter int SLICE = 8,
    parameter int CW    = $clog2(SLICE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [N-1:0]  ptr,
    output logic [CW-1:0] slice_cnt,
    output logic          timeout,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_CW   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SLICE_CW = CW'(SLICE);

    logic [1:0]   state;
    logic [N-1:0] mask_hi;
    logic [N-1:0] req_hi;
    logic [N-1:0] winner;
    logic         expired;
    logic         still_req;
    logic         release_now;

    // Winner search: lowest requester at or above the token, else lowest overall (wrap).
    // ptr is one-hot, so ptr-1 marks every bit below the token.
    always_comb begin
        mask_hi = ~(ptr - ONE_N);
        req_hi  = req & mask_hi;
        if (|req_hi) begin
            winner = req_hi & (~req_hi + ONE_N);
        end else begin
            winner = req & (~req + ONE_N);
        end
    end

    // Release decision for the live grant; a dropped req wins over expiry for the timeout flag.
    always_comb begin
        expired     = (slice_cnt == SLICE_CW);
        still_req   = |(req & grant);
        release_now = !still_req || expired;
    end

    // Arbitration state machine; all outputs other than the ORs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            ptr       <= ONE_N;
            slice_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    timeout <= 1'b0;
                    if (en && (|req)) begin
                        grant     <= winner;
                        slice_cnt <= ONE_CW;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        grant     <= '0;
                        slice_cnt <= '0;
                        // Token moves just past the requester that was served.
                        ptr       <= {grant[N-2:0], grant[N-1]};
                        timeout   <= expired && still_req;
                        state     <= S_GAP;
                    end else begin
                        slice_cnt <= slice_cnt + ONE_CW;
                        timeout   <= 1'b0;
                    end
                end
                S_GAP: begin
                    timeout <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    grant     <= '0;
                    slice_cnt <= '0;
                    timeout   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = |grant;
    assign busy        = (state != S_IDLE);

endmodule
